// File: rtl/ps2_key_event_queue.sv
// PS/2 scancode decoder and key-event queue.
// Turns the raw receiver byte stream (E0/F0/E1 prefixes) into press/release
// events, tracks held keys, and buffers events in a show-ahead FIFO.
module ps2_key_event_queue #(
  parameter int FIFO_DEPTH      = 8,
  parameter bit SUPPRESS_REPEAT = 1'b1,
  parameter bit IGNORE_CTRL     = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          rx_overflow,
  output logic [9:0]                    evt_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          drop_flag,
  input  logic                          drop_clr,
  output logic [8:0]                    keys_down,
  output logic [31:0]                   cur_key
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_REL, S_EXT_REL, S_PAUSE} state_t;

  state_t        r_state, w_state_next;
  logic [2:0]    r_skip, w_skip_next;
  logic [511:0]  r_held;
  logic [8:0]    r_keys_down;
  logic [31:0]   r_cur_key;
  logic          r_drop_flag;
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_emit, w_rel, w_ext, w_pause, w_ctrl;
  logic [7:0]    w_code;
  logic [8:0]    w_idx;
  logic          w_held_bit, w_suppress, w_accept, w_set, w_clr;
  logic          w_full, w_pop, w_write, w_drop;
  logic [31:0]   w_cur_key_next;

  // Link-level housekeeping bytes that never represent a key in IDLE.
  assign w_ctrl = IGNORE_CTRL && (rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF});

  // Prefix decoder: next state, pause countdown and the decoded event.
  always_comb begin
    w_state_next = r_state;
    w_skip_next  = r_skip;
    w_emit       = 1'b0;
    w_rel        = 1'b0;
    w_ext        = 1'b0;
    w_pause      = 1'b0;
    w_code       = rx_data;
    if (rx_overflow) begin
      w_state_next = S_IDLE;
      w_skip_next  = 3'd0;
    end else if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == 8'hE0) w_state_next = S_EXT;
          else if (rx_data == 8'hF0) w_state_next = S_REL;
          else if (rx_data == 8'hE1) begin
            w_state_next = S_PAUSE;
            w_skip_next  = 3'd7;
          end else if (!w_ctrl) w_emit = 1'b1;
        end
        S_EXT: begin
          if (rx_data == 8'hF0) w_state_next = S_EXT_REL;
          else if (rx_data == 8'hE0) w_state_next = S_EXT;
          else if (rx_data == 8'hE1) begin
            w_state_next = S_PAUSE;
            w_skip_next  = 3'd7;
          end else begin
            w_emit       = 1'b1;
            w_ext        = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        S_REL: begin
          w_emit       = 1'b1;
          w_rel        = 1'b1;
          w_state_next = S_IDLE;
        end
        S_EXT_REL: begin
          w_emit       = 1'b1;
          w_rel        = 1'b1;
          w_ext        = 1'b1;
          w_state_next = S_IDLE;
        end
        S_PAUSE: begin
          w_skip_next = 3'(r_skip - 3'd1);
          if (r_skip <= 3'd1) begin
            w_emit       = 1'b1;
            w_ext        = 1'b1;
            w_pause      = 1'b1;
            w_code       = 8'h77;
            w_skip_next  = 3'd0;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Pause is a pseudo-key: always queued, never tracked in the bitmap.
  assign w_idx      = {w_ext, w_code};
  assign w_held_bit = r_held[w_idx];
  assign w_suppress = SUPPRESS_REPEAT && w_emit && !w_rel && !w_pause && w_held_bit;
  assign w_accept   = w_emit && !w_suppress;
  assign w_set      = w_emit && !w_rel && !w_pause && !w_held_bit;
  assign w_clr      = w_emit && w_rel && w_held_bit;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = (r_count != '0) && evt_ready;
  assign w_write = w_accept && (!w_full || w_pop);
  assign w_drop  = w_accept && w_full && !w_pop;

  // Legacy last-key word encodes prefixes the way the keyboard sent them.
  always_comb begin
    case ({w_ext, w_rel})
      2'b00:   w_cur_key_next = {24'h000000, w_code};
      2'b01:   w_cur_key_next = {16'h0000, 8'hF0, w_code};
      2'b10:   w_cur_key_next = {16'h0000, 8'hE0, w_code};
      default: w_cur_key_next = {8'h00, 8'hE0, 8'hF0, w_code};
    endcase
  end

  // Decoder state, held-key bitmap, key counter and legacy word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_skip      <= 3'd0;
      r_held      <= '0;
      r_keys_down <= 9'd0;
      r_cur_key   <= 32'h0000F01B;
      r_drop_flag <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_skip  <= w_skip_next;
      if (w_set) begin
        r_held[w_idx] <= 1'b1;
        if (r_keys_down != 9'h1FF) r_keys_down <= r_keys_down + 9'd1;
      end else if (w_clr) begin
        r_held[w_idx] <= 1'b0;
        if (r_keys_down != 9'd0) r_keys_down <= r_keys_down - 9'd1;
      end
      if (w_accept) r_cur_key <= w_cur_key_next;
      // A drop in the same cycle as a clear must remain visible.
      if (w_drop) r_drop_flag <= 1'b1;
      else if (drop_clr) r_drop_flag <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Event storage; contents are only meaningful behind r_count.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= {w_rel, w_ext, w_code};
  end

  assign evt_valid = (r_count != '0);
  assign evt_data  = evt_valid ? r_mem[r_rd_ptr] : 10'd0;
  assign evt_count = r_count;
  assign drop_flag = r_drop_flag;
  assign keys_down = r_keys_down;
  assign cur_key   = r_cur_key;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue (default build plus a
// repeat-passthrough build driven by the same stimulus).
module tb_ps2_key_event_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_overflow = 1'b0;
  logic        evt_ready = 1'b0;
  logic        drop_clr = 1'b0;

  logic [9:0]  evt_data, evt_data2;
  logic        evt_valid, evt_valid2;
  logic [3:0]  evt_count, evt_count2;
  logic        drop_flag, drop_flag2;
  logic [8:0]  keys_down, keys_down2;
  logic [31:0] cur_key, cur_key2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ps2_key_event_queue #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(1'b1), .IGNORE_CTRL(1'b1)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_overflow(rx_overflow),
    .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_count(evt_count),
    .drop_flag(drop_flag), .drop_clr(drop_clr), .keys_down(keys_down), .cur_key(cur_key)
  );

  ps2_key_event_queue #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(1'b0), .IGNORE_CTRL(1'b1)) dut_rep (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_overflow(rx_overflow),
    .evt_data(evt_data2), .evt_valid(evt_valid2), .evt_ready(evt_ready), .evt_count(evt_count2),
    .drop_flag(drop_flag2), .drop_clr(drop_clr), .keys_down(keys_down2), .cur_key(cur_key2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    $display("rx byte %h -> valid=%0d data=%h count=%0d keys=%0d cur_key=%h",
             b, evt_valid, evt_data, evt_count, keys_down, cur_key);
  endtask

  task automatic pop();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0d want 0", evt_valid); end
    checks++; if (evt_count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", evt_count); end
    checks++; if (evt_data !== 10'h000) begin errors++; $display("FAIL rst_data: got %h want 000", evt_data); end
    checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL rst_drop: got %0d want 0", drop_flag); end
    checks++; if (keys_down !== 9'd0) begin errors++; $display("FAIL rst_keys: got %0d want 0", keys_down); end
    checks++; if (cur_key !== 32'h0000F01B) begin errors++; $display("FAIL rst_cur_key: got %h want 0000F01B", cur_key); end
  endtask

  task automatic test_press_release();
    do_reset();
    rx_data = 8'h1C; rx_valid = 1'b1;
    #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL pr_latency: got %0d want 0", evt_valid); end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL pr_valid: got %0d want 1", evt_valid); end
    checks++; if (evt_data !== 10'h01C) begin errors++; $display("FAIL pr_data: got %h want 01C", evt_data); end
    checks++; if (cur_key !== 32'h0000001C) begin errors++; $display("FAIL pr_cur_key: got %h want 0000001C", cur_key); end
    checks++; if (keys_down !== 9'd1) begin errors++; $display("FAIL pr_keys: got %0d want 1", keys_down); end
    pop();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL pr_pop: got %0d want 0", evt_valid); end
    send(8'hF0);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rel_prefix: got %0d want 0", evt_valid); end
    send(8'h1C);
    checks++; if (evt_data !== 10'h21C) begin errors++; $display("FAIL rel_data: got %h want 21C", evt_data); end
    checks++; if (cur_key !== 32'h0000F01C) begin errors++; $display("FAIL rel_cur_key: got %h want 0000F01C", cur_key); end
    checks++; if (keys_down !== 9'd0) begin errors++; $display("FAIL rel_keys: got %0d want 0", keys_down); end
    pop();
  endtask

  task automatic test_extended();
    do_reset();
    send(8'hE0); send(8'h75);
    checks++; if (evt_data !== 10'h175) begin errors++; $display("FAIL ext_press: got %h want 175", evt_data); end
    checks++; if (cur_key !== 32'h0000E075) begin errors++; $display("FAIL ext_press_key: got %h want 0000E075", cur_key); end
    checks++; if (keys_down !== 9'd1) begin errors++; $display("FAIL ext_keys: got %0d want 1", keys_down); end
    pop();
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++; if (evt_data !== 10'h375) begin errors++; $display("FAIL ext_rel: got %h want 375", evt_data); end
    checks++; if (cur_key !== 32'h00E0F075) begin errors++; $display("FAIL ext_rel_key: got %h want 00E0F075", cur_key); end
    checks++; if (keys_down !== 9'd0) begin errors++; $display("FAIL ext_rel_keys: got %0d want 0", keys_down); end
    pop();
  endtask

  task automatic test_repeat();
    logic [8:0] peak;
    peak = 9'd0;
    do_reset();
    send(8'h1C); if (keys_down > peak) peak = keys_down;
    send(8'h1C); if (keys_down > peak) peak = keys_down;
    send(8'h1C); if (keys_down > peak) peak = keys_down;
    send(8'hF0); if (keys_down > peak) peak = keys_down;
    send(8'h1C); if (keys_down > peak) peak = keys_down;
    checks++; if (evt_count !== 4'd2) begin errors++; $display("FAIL rep_suppress_count: got %0d want 2", evt_count); end
    checks++; if (evt_count2 !== 4'd4) begin errors++; $display("FAIL rep_pass_count: got %0d want 4", evt_count2); end
    checks++; if (peak !== 9'd1) begin errors++; $display("FAIL rep_peak: got %0d want 1", peak); end
    checks++; if (keys_down2 !== 9'd0) begin errors++; $display("FAIL rep_pass_keys: got %0d want 0", keys_down2); end
    checks++; if (evt_data !== 10'h01C) begin errors++; $display("FAIL rep_head: got %h want 01C", evt_data); end
  endtask

  task automatic test_fifo_full();
    logic [9:0] exp;
    do_reset();
    for (int i = 0; i < 9; i++) send(8'(8'h10 + i));
    checks++; if (evt_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", evt_count); end
    checks++; if (drop_flag !== 1'b1) begin errors++; $display("FAIL full_drop: got %0d want 1", drop_flag); end
    checks++; if (evt_data !== 10'h010) begin errors++; $display("FAIL full_head: got %h want 010", evt_data); end
    checks++; if (keys_down !== 9'd9) begin errors++; $display("FAIL full_keys: got %0d want 9", keys_down); end
    checks++; if (cur_key !== 32'h00000018) begin errors++; $display("FAIL full_cur_key: got %h want 00000018", cur_key); end
    drop_clr = 1'b1;
    send(8'h1A);
    drop_clr = 1'b0;
    checks++; if (drop_flag !== 1'b1) begin errors++; $display("FAIL drop_vs_clr: got %0d want 1", drop_flag); end
    evt_ready = 1'b1;
    send(8'h19);
    evt_ready = 1'b0;
    checks++; if (evt_count !== 4'd8) begin errors++; $display("FAIL full_pushpop_count: got %0d want 8", evt_count); end
    checks++; if (evt_data !== 10'h011) begin errors++; $display("FAIL full_pushpop_head: got %h want 011", evt_data); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 10'(8'h11 + i) : 10'h019;
      checks++; if (evt_data !== exp) begin errors++; $display("FAIL drain_%0d: got %h want %h", i, evt_data, exp); end
      $display("pop %0d -> %h", i, evt_data);
      pop();
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %0d want 0", evt_valid); end
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL drop_clear: got %0d want 0", drop_flag); end
  endtask

  task automatic test_pause();
    do_reset();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    checks++; if (evt_count !== 4'd0) begin errors++; $display("FAIL pause_early: got %0d want 0", evt_count); end
    send(8'h77);
    checks++; if (evt_count !== 4'd1) begin errors++; $display("FAIL pause_count: got %0d want 1", evt_count); end
    checks++; if (evt_data !== 10'h177) begin errors++; $display("FAIL pause_data: got %h want 177", evt_data); end
    checks++; if (keys_down !== 9'd0) begin errors++; $display("FAIL pause_keys: got %0d want 0", keys_down); end
    checks++; if (cur_key !== 32'h0000E077) begin errors++; $display("FAIL pause_cur_key: got %h want 0000E077", cur_key); end
    send(8'hFA);
    checks++; if (evt_count !== 4'd1) begin errors++; $display("FAIL ack_ignored: got %0d want 1", evt_count); end
    pop();
  endtask

  task automatic test_overflow();
    do_reset();
    send(8'hE0);
    rx_overflow = 1'b1;
    tick();
    rx_overflow = 1'b0;
    send(8'h1C);
    checks++; if (evt_data !== 10'h01C) begin errors++; $display("FAIL ovf_prefix: got %h want 01C", evt_data); end
    rx_overflow = 1'b1;
    send(8'h1D);
    rx_overflow = 1'b0;
    checks++; if (evt_count !== 4'd1) begin errors++; $display("FAIL ovf_byte: got %0d want 1", evt_count); end
    checks++; if (keys_down !== 9'd1) begin errors++; $display("FAIL ovf_keys: got %0d want 1", keys_down); end
    pop();
  endtask

  task automatic test_back_to_back();
    do_reset();
    evt_ready = 1'b1;
    send(8'h21);
    checks++; if (evt_count !== 4'd1) begin errors++; $display("FAIL empty_pushpop: got %0d want 1", evt_count); end
    checks++; if (evt_data !== 10'h021) begin errors++; $display("FAIL empty_pushpop_data: got %h want 021", evt_data); end
    tick();
    evt_ready = 1'b0;
    checks++; if (evt_count !== 4'd0) begin errors++; $display("FAIL b2b_drain: got %0d want 0", evt_count); end
    send(8'h22); send(8'h23); send(8'h24);
    checks++; if (evt_count !== 4'd3) begin errors++; $display("FAIL b2b_count: got %0d want 3", evt_count); end
    reset = 1'b1;
    #2;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %0d want 0", evt_valid); end
    checks++; if (evt_count !== 4'd0) begin errors++; $display("FAIL async_rst_count: got %0d want 0", evt_count); end
    checks++; if (cur_key !== 32'h0000F01B) begin errors++; $display("FAIL async_rst_key: got %h want 0000F01B", cur_key); end
    checks++; if (keys_down !== 9'd0) begin errors++; $display("FAIL async_rst_keys: got %0d want 0", keys_down); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_extended();
    test_repeat();
    test_fifo_full();
    test_pause();
    test_overflow();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
